// File: rtl/pe_traffic_gen.sv
// Synthetic NoC leaf PE: injects addressed packets and sinks/counts received ones.
// Optional RX stall pattern: define PE_RX_BACKPRESSURE_EN.
module pe_traffic_gen #(
  parameter int ADDRESS  = 0,
  parameter int ADDR_W   = 2,
  parameter int NUM_PKTS = 8,
  parameter int INJ_GAP  = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  output logic [31:0]      o_data,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  input  logic [31:0]      i_data,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  output logic [CNT_W-1:0] o_tx_count,
  output logic [CNT_W-1:0] o_rx_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_done
);

  localparam int SEQ_W = 32 - 2 * ADDR_W;
  localparam int GW = (INJ_GAP > 1) ? $clog2(INJ_GAP) : 1;
  localparam logic [ADDR_W-1:0] SRC = ADDR_W'(ADDRESS);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((INJ_GAP > 0) ? INJ_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] LAST_PKT =
    CNT_W'((NUM_PKTS > 0) ? NUM_PKTS - 1 : 0);
  localparam bit LIMITED = (NUM_PKTS != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state;
  logic [SEQ_W-1:0]  seq;
  logic [ADDR_W-1:0] dest;
  logic [GW-1:0]     gap_cnt;
  logic              tx_fire;
  logic              rx_fire;
  logic              rx_unused;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Round-robin over all nodes except our own address
  function automatic logic [ADDR_W-1:0] next_dest(
    input logic [ADDR_W-1:0] d
  );
    logic [ADDR_W-1:0] n;
    n = d + ADDR_W'(1);
    if (n == SRC) n = n + ADDR_W'(1);
    return n;
  endfunction

  function automatic logic [31:0] pack(
    input logic [SEQ_W-1:0]  s,
    input logic [ADDR_W-1:0] d
  );
    return {s, SRC, d};
  endfunction

  assign tx_fire   = o_data_valid & i_data_ready;
  assign rx_fire   = i_data_valid & o_data_ready;
  assign rx_unused = ^i_data[31:ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      seq          <= '0;
      dest         <= SRC + ADDR_W'(1);
      gap_cnt      <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_done       <= 1'b0;
      o_tx_count   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_enable) begin
            state        <= S_SEND;
            o_data_valid <= 1'b1;
            o_data       <= pack(seq, dest);
          end
        end
        S_SEND: begin
          if (tx_fire) begin
            o_tx_count <= sat_inc(o_tx_count);
            seq        <= seq + SEQ_W'(1);
            dest       <= next_dest(dest);
            if (LIMITED && o_tx_count == LAST_PKT) begin
              state        <= S_DONE;
              o_data_valid <= 1'b0;
              o_done       <= 1'b1;
            end else if (INJ_GAP == 0) begin
              o_data <= pack(seq + SEQ_W'(1), next_dest(dest));
            end else if (!i_enable) begin
              state        <= S_IDLE;
              o_data_valid <= 1'b0;
            end else begin
              state        <= S_GAP;
              o_data_valid <= 1'b0;
              gap_cnt      <= '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (i_enable) begin
              state        <= S_SEND;
              o_data_valid <= 1'b1;
              o_data       <= pack(seq, dest);
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_DONE: begin
          o_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rx_count  <= '0;
      o_err_count <= '0;
    end else if (rx_fire) begin
      o_rx_count <= sat_inc(o_rx_count);
      if (i_data[ADDR_W-1:0] != SRC)
        o_err_count <= sat_inc(o_err_count);
    end
  end

`ifdef PE_RX_BACKPRESSURE_EN
  logic [1:0] bp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bp_cnt <= 2'd0;
    else        bp_cnt <= bp_cnt + 2'd1;
  end

  assign o_data_ready = (bp_cnt != 2'd3);
`else
  assign o_data_ready = 1'b1;
`endif

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Bench for pe_traffic_gen: directed sequences plus randomized
// ready/RX traffic against a packet-level reference model.
module tb_pe_traffic_gen;

  localparam int N  = 4;
  localparam int CG = 1;
  localparam int CSAT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic a_en, a_rdy, a_dv, a_vld, a_dr, a_done;
  logic [31:0] a_din, a_dout;
  logic [15:0] a_tx, a_rx, a_err;
  logic b_en, b_rdy, b_dv, b_vld, b_dr, b_done;
  logic [31:0] b_din, b_dout;
  logic [15:0] b_tx, b_rx, b_err;
  logic c_en, c_rdy, c_dv, c_vld, c_dr, c_done;
  logic [31:0] c_din, c_dout;
  logic [3:0] c_tx, c_rx, c_err;

  pe_traffic_gen #(.ADDRESS(1), .NUM_PKTS(3), .INJ_GAP(2)) u_a (
    .clk(clk), .rst_n(rst_n), .i_enable(a_en),
    .o_data(a_dout), .o_data_valid(a_vld),
    .i_data_ready(a_rdy), .i_data(a_din),
    .i_data_valid(a_dv), .o_data_ready(a_dr),
    .o_tx_count(a_tx), .o_rx_count(a_rx),
    .o_err_count(a_err), .o_done(a_done));

  pe_traffic_gen #(.ADDRESS(2), .NUM_PKTS(4), .INJ_GAP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .i_enable(b_en),
    .o_data(b_dout), .o_data_valid(b_vld),
    .i_data_ready(b_rdy), .i_data(b_din),
    .i_data_valid(b_dv), .o_data_ready(b_dr),
    .o_tx_count(b_tx), .o_rx_count(b_rx),
    .o_err_count(b_err), .o_done(b_done));

  pe_traffic_gen #(.ADDRESS(1), .NUM_PKTS(0), .INJ_GAP(CG),
                   .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .i_enable(c_en),
    .o_data(c_dout), .o_data_valid(c_vld),
    .i_data_ready(c_rdy), .i_data(c_din),
    .i_data_valid(c_dv), .o_data_ready(c_dr),
    .o_tx_count(c_tx), .o_rx_count(c_rx),
    .o_err_count(c_err), .o_done(c_done));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // k-th packet from node addr: dests cycle through the other nodes
  function automatic logic [31:0] pkt(input int addr, input int k);
    int d;
    d = (addr + 1 + k % (N - 1)) % N;
    return (k << 4) | (addr << 2) | d;
  endfunction

  function automatic int exp_rdy(input int c);
`ifdef PE_RX_BACKPRESSURE_EN
    return (c % 4 == 3) ? 0 : 1;
`else
    return (c >= 0) ? 1 : 0;
`endif
  endfunction

  function automatic int sat(input int v);
    return (v > CSAT) ? CSAT : v;
  endfunction

  int ev, kk, lo, nrx, nerr, pv, txf, rxf, dlow, r, dv, got;
  logic [31:0] rxv [3];

  initial begin
    a_en = 0; a_rdy = 0; a_dv = 0; a_din = '0;
    b_en = 0; b_rdy = 0; b_dv = 0; b_din = '0;
    c_en = 0; c_rdy = 0; c_dv = 0; c_din = '0;
    #2;
    chk("rst_valid", 32'(a_vld), 0);
    chk("rst_data", a_dout, 0);
    chk("rst_tx", 32'(a_tx), 0);
    chk("rst_rx", 32'(a_rx), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_ready", 32'(a_dr), 1);
    chk("rst_ready_c", 32'(c_dr), 1);

    @(posedge clk); #1;
    rst_n = 1; cyc = 0;
    a_en = 1; a_rdy = 1; b_en = 1; b_rdy = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      ev = (i % 3 == 0 && i / 3 < 3) ? 1 : 0;
      chk("seq_valid", 32'(a_vld), ev);
      if (ev != 0) chk("seq_data", a_dout, pkt(1, i / 3));
      chk("seq_tx", 32'(a_tx), ((i + 2) / 3 > 3) ? 3 : (i + 2) / 3);
      chk("seq_done", 32'(a_done), (i >= 7) ? 1 : 0);
      ev = (i < 4) ? 1 : 0;
      chk("b2b_valid", 32'(b_vld), ev);
      if (ev != 0) chk("b2b_data", b_dout, pkt(2, i));
      chk("b2b_tx", 32'(b_tx), (i > 4) ? 4 : i);
      chk("b2b_done", 32'(b_done), (i >= 4) ? 1 : 0);
    end
    a_en = 0; b_en = 0;

    c_en = 1; c_rdy = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(c_vld), 1);
      chk("hold_data", c_dout, pkt(1, 0));
      chk("hold_tx", 32'(c_tx), 0);
      step();
    end
    c_rdy = 1;
    step();
    c_rdy = 0;
    chk("hold_xfer_tx", 32'(c_tx), 1);
    chk("hold_gap_valid", 32'(c_vld), 0);
    step();
    chk("hold_next_valid", 32'(c_vld), 1);
    chk("hold_next_data", c_dout, pkt(1, 1));

    ev = 1; kk = 1; lo = 0; nrx = 0; nerr = 0;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 1));
      dv = int'($urandom_range(0, 1));
      c_rdy = r[0];
      c_dv = dv[0];
      c_din = $urandom;
      chk("rnd_ready", 32'(c_dr), exp_rdy(cyc));
      txf = (ev != 0 && r != 0) ? 1 : 0;
      rxf = (dv != 0 && exp_rdy(cyc) != 0) ? 1 : 0;
      dlow = (c_din[1:0] != 2'd1) ? 1 : 0;
      pv = ev;
      step();
      if (txf != 0) begin
        kk++; ev = 0; lo = CG;
      end else if (pv == 0) begin
        lo--;
        if (lo == 0) ev = 1;
      end
      if (rxf != 0) begin
        nrx++;
        if (dlow != 0) nerr++;
      end
      chk("rnd_valid", 32'(c_vld), ev);
      if (ev != 0) chk("rnd_data", c_dout, pkt(1, kk));
      chk("rnd_tx", 32'(c_tx), sat(kk));
      chk("rnd_rx", 32'(c_rx), sat(nrx));
      chk("rnd_err", 32'(c_err), sat(nerr));
    end
    c_dv = 0;

    rxv[0] = 32'h0000_0001;
    rxv[1] = 32'h0000_0015;
    rxv[2] = 32'h0000_0002;
    for (int j = 0; j < 3; j++) begin
      got = 0;
      for (int t = 0; t < 4 && got == 0; t++) begin
        a_dv = 1; a_din = rxv[j];
        got = exp_rdy(cyc);
        step();
      end
    end
    a_dv = 0;
    chk("rx_count", 32'(a_rx), 3);
    chk("rx_err", 32'(a_err), 1);

    c_rdy = 0;
    step(); step(); step();
    chk("mid_pending", 32'(c_vld), 1);
    #3;
    rst_n = 0;
    #1;
    chk("mid_valid", 32'(c_vld), 0);
    chk("mid_tx", 32'(c_tx), 0);
    chk("mid_rx", 32'(c_rx), 0);
    chk("mid_err", 32'(c_err), 0);
    chk("mid_a_tx", 32'(a_tx), 0);
    chk("mid_a_rx", 32'(a_rx), 0);
    chk("mid_a_done", 32'(a_done), 0);
    chk("mid_b_done", 32'(b_done), 0);

    @(posedge clk); #1;
    rst_n = 1; cyc = 0;
    c_en = 1; c_rdy = 1; c_dv = 1; c_din = 32'h0000_0001;
    for (int i = 0; i < 8; i++) begin
      chk("bp_ready", 32'(c_dr), exp_rdy(i));
      if (i == 1) begin
        chk("restart_valid", 32'(c_vld), 1);
        chk("restart_data", c_dout, 32'h0000_0006);
      end
      step();
    end
    c_dv = 0;
`ifdef PE_RX_BACKPRESSURE_EN
    chk("bp_rx", 32'(c_rx), 6);
`else
    chk("bp_rx", 32'(c_rx), 8);
`endif
    chk("bp_err", 32'(c_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
